// File: rtl/axi_lite_multicut_cfg.sv
// AXI-Lite multi-stage register slice. Each of the five channels is an
// independent chain of AW/W/B/AR/R_CUTS stages; CUT_MODE picks a full
// spill stage (0) or a forward-only stage (1) for every stage.

// One register stage: MODE 0 = two-entry spill stage with registered
// upstream ready, MODE 1 = one-entry forward stage with pass-through ready.
module axi_lite_multicut_stage #(
   parameter int W    = 1,
   parameter int MODE = 0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         s_valid_i,
   input  logic [W-1:0] s_data_i,
   output logic         s_ready_o,
   output logic         m_valid_o,
   output logic [W-1:0] m_data_o,
   input  logic         m_ready_i,
   output logic         busy_o
);
   if (MODE == 1) begin : g_fwd
      logic         vld_q;
      logic [W-1:0] dat_q;
      logic         push;

      assign s_ready_o = !vld_q || m_ready_i;
      assign push      = s_valid_i && s_ready_o;
      assign m_valid_o = vld_q;
      assign m_data_o  = dat_q;
      assign busy_o    = vld_q;

      // Valid flag: set on push, cleared when the beat leaves without a replacement.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)        vld_q <= 1'b0;
         else if (push)      vld_q <= 1'b1;
         else if (m_ready_i) vld_q <= 1'b0;
      end

      // Payload capture; a push during a pop replaces the entry in one cycle.
      always_ff @(posedge clk_i) begin
         if (push) dat_q <= s_data_i;
      end
   end else begin : g_full
      typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
      state_e       state_q, state_d;
      logic         rdy_q;
      logic [W-1:0] main_q, main_d, spill_q, spill_d;
      logic         push, pop;

      assign push      = s_valid_i && rdy_q;
      assign pop       = (state_q != EMPTY) && m_ready_i;
      assign s_ready_o = rdy_q;
      assign m_valid_o = (state_q != EMPTY);
      assign m_data_o  = main_q;
      assign busy_o    = (state_q != EMPTY);

      // Occupancy state and registered ready (ready means the spill slot is free).
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != TWO);
         end
      end

      // Entry storage; held beats are not cleared by reset, only invalidated.
      always_ff @(posedge clk_i) begin
         main_q  <= main_d;
         spill_q <= spill_d;
      end

      // Next-state: output always comes from main, spill absorbs the late beat.
      always_comb begin
         state_d = state_q;
         main_d  = main_q;
         spill_d = spill_q;
         unique case (state_q)
            EMPTY: if (push) begin
               state_d = ONE;
               main_d  = s_data_i;
            end
            ONE: begin
               if (push && pop) begin
                  main_d = s_data_i;
               end else if (push) begin
                  state_d = TWO;
                  spill_d = s_data_i;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (pop) begin
               state_d = ONE;
               main_d  = spill_q;
            end
            default: state_d = EMPTY;
         endcase
      end
   end
endmodule

// Chain of CUTS stages; zero stages is a plain wire on every signal.
module axi_lite_multicut_chain #(
   parameter int W    = 1,
   parameter int CUTS = 1,
   parameter int MODE = 0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         s_valid_i,
   input  logic [W-1:0] s_data_i,
   output logic         s_ready_o,
   output logic         m_valid_o,
   output logic [W-1:0] m_data_o,
   input  logic         m_ready_i,
   output logic         busy_o
);
   if (CUTS <= 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = clk_i ^ rst_ni;
      assign m_valid_o  = s_valid_i;
      assign m_data_o   = s_data_i;
      assign s_ready_o  = m_ready_i;
      assign busy_o     = 1'b0;
   end else begin : g_cut
      logic [CUTS:0]        vld, rdy;
      logic [CUTS:0][W-1:0] dat;
      logic [CUTS-1:0]      bsy;

      assign vld[0]    = s_valid_i;
      assign dat[0]    = s_data_i;
      assign s_ready_o = rdy[0];
      assign m_valid_o = vld[CUTS];
      assign m_data_o  = dat[CUTS];
      assign rdy[CUTS] = m_ready_i;
      assign busy_o    = |bsy;

      for (genvar i = 0; i < CUTS; i++) begin : g_stage
         axi_lite_multicut_stage #(.W(W), .MODE(MODE)) u_stage (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .s_valid_i(vld[i]),
            .s_data_i (dat[i]),
            .s_ready_o(rdy[i]),
            .m_valid_o(vld[i+1]),
            .m_data_o (dat[i+1]),
            .m_ready_i(rdy[i+1]),
            .busy_o   (bsy[i])
         );
      end
   end
endmodule

module axi_lite_multicut_cfg #(
   parameter int ADDR_WIDTH = -1,
   parameter int DATA_WIDTH = -1,
   parameter int AW_CUTS    = 1,
   parameter int W_CUTS     = 1,
   parameter int B_CUTS     = 1,
   parameter int AR_CUTS    = 1,
   parameter int R_CUTS     = 1,
   parameter int CUT_MODE   = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_WIDTH-1:0]   in_aw_addr_i,
   input  logic [2:0]              in_aw_prot_i,
   input  logic                    in_aw_valid_i,
   output logic                    in_aw_ready_o,
   input  logic [DATA_WIDTH-1:0]   in_w_data_i,
   input  logic [DATA_WIDTH/8-1:0] in_w_strb_i,
   input  logic                    in_w_valid_i,
   output logic                    in_w_ready_o,
   output logic [1:0]              in_b_resp_o,
   output logic                    in_b_valid_o,
   input  logic                    in_b_ready_i,
   input  logic [ADDR_WIDTH-1:0]   in_ar_addr_i,
   input  logic [2:0]              in_ar_prot_i,
   input  logic                    in_ar_valid_i,
   output logic                    in_ar_ready_o,
   output logic [DATA_WIDTH-1:0]   in_r_data_o,
   output logic [1:0]              in_r_resp_o,
   output logic                    in_r_valid_o,
   input  logic                    in_r_ready_i,
   output logic [ADDR_WIDTH-1:0]   out_aw_addr_o,
   output logic [2:0]              out_aw_prot_o,
   output logic                    out_aw_valid_o,
   input  logic                    out_aw_ready_i,
   output logic [DATA_WIDTH-1:0]   out_w_data_o,
   output logic [DATA_WIDTH/8-1:0] out_w_strb_o,
   output logic                    out_w_valid_o,
   input  logic                    out_w_ready_i,
   input  logic [1:0]              out_b_resp_i,
   input  logic                    out_b_valid_i,
   output logic                    out_b_ready_o,
   output logic [ADDR_WIDTH-1:0]   out_ar_addr_o,
   output logic [2:0]              out_ar_prot_o,
   output logic                    out_ar_valid_o,
   input  logic                    out_ar_ready_i,
   input  logic [DATA_WIDTH-1:0]   out_r_data_i,
   input  logic [1:0]              out_r_resp_i,
   input  logic                    out_r_valid_i,
   output logic                    out_r_ready_o,
   output logic                    busy_o
);
   localparam int AX_W = ADDR_WIDTH + 3;
   localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8;
   localparam int R_W  = DATA_WIDTH + 2;
   localparam bit CFG_OK = (ADDR_WIDTH >= 1) && (DATA_WIDTH >= 8) && (DATA_WIDTH % 8 == 0) &&
                           (AW_CUTS >= 0) && (W_CUTS >= 0) && (B_CUTS >= 0) &&
                           (AR_CUTS >= 0) && (R_CUTS >= 0) && (CUT_MODE == 0 || CUT_MODE == 1);

   logic aw_busy, w_busy, b_busy, ar_busy, r_busy;

   // Stop simulation on an illegal parameter set.
   always_ff @(posedge clk_i) begin
      assert (CFG_OK) else $fatal(1, "axi_lite_multicut_cfg: illegal parameters");
   end

   axi_lite_multicut_chain #(.W(AX_W), .CUTS(AW_CUTS), .MODE(CUT_MODE)) u_aw (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_valid_i(in_aw_valid_i), .s_data_i({in_aw_prot_i, in_aw_addr_i}), .s_ready_o(in_aw_ready_o),
      .m_valid_o(out_aw_valid_o), .m_data_o({out_aw_prot_o, out_aw_addr_o}), .m_ready_i(out_aw_ready_i),
      .busy_o(aw_busy));

   axi_lite_multicut_chain #(.W(W_W), .CUTS(W_CUTS), .MODE(CUT_MODE)) u_w (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_valid_i(in_w_valid_i), .s_data_i({in_w_strb_i, in_w_data_i}), .s_ready_o(in_w_ready_o),
      .m_valid_o(out_w_valid_o), .m_data_o({out_w_strb_o, out_w_data_o}), .m_ready_i(out_w_ready_i),
      .busy_o(w_busy));

   axi_lite_multicut_chain #(.W(2), .CUTS(B_CUTS), .MODE(CUT_MODE)) u_b (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_valid_i(out_b_valid_i), .s_data_i(out_b_resp_i), .s_ready_o(out_b_ready_o),
      .m_valid_o(in_b_valid_o), .m_data_o(in_b_resp_o), .m_ready_i(in_b_ready_i),
      .busy_o(b_busy));

   axi_lite_multicut_chain #(.W(AX_W), .CUTS(AR_CUTS), .MODE(CUT_MODE)) u_ar (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_valid_i(in_ar_valid_i), .s_data_i({in_ar_prot_i, in_ar_addr_i}), .s_ready_o(in_ar_ready_o),
      .m_valid_o(out_ar_valid_o), .m_data_o({out_ar_prot_o, out_ar_addr_o}), .m_ready_i(out_ar_ready_i),
      .busy_o(ar_busy));

   axi_lite_multicut_chain #(.W(R_W), .CUTS(R_CUTS), .MODE(CUT_MODE)) u_r (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_valid_i(out_r_valid_i), .s_data_i({out_r_resp_i, out_r_data_i}), .s_ready_o(out_r_ready_o),
      .m_valid_o(in_r_valid_o), .m_data_o({in_r_resp_o, in_r_data_o}), .m_ready_i(in_r_ready_i),
      .busy_o(r_busy));

   assign busy_o = aw_busy | w_busy | b_busy | ar_busy | r_busy;
endmodule

// File: tb/tb_axi_lite_multicut_cfg.sv
// Bench for axi_lite_multicut_cfg: two instances (full-stage and forward-stage
// configurations), a queue scoreboard per channel, and directed scenarios.
module tb_axi_lite_multicut_cfg;
   // Channel index = inst*5 + {0:AW, 1:W, 2:B, 3:AR, 4:R}; "src" is the beat producer side.
   logic        clk, rst_n;
   logic        src_vld [10];
   logic [63:0] src_dat [10];
   logic        dst_rdy [10];
   wire         src_rdy [10];
   wire         dst_vld [10];
   wire  [63:0] dst_dat [10];
   wire         busy    [2];

   int n_chk, n_pass, stamp;
   logic [63:0] sbq [10][$];
   int          tsq [10][$];

   function automatic int ncut(input int ch);
      case (ch)
         0: return 3;  1: return 2;  2: return 1;  3: return 0;  4: return 2;
         5: return 1;  6: return 0;  7: return 2;  8: return 1;  9: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [63:0] cmask(input int ch);
      case (ch % 5)
         1:       return (64'd1 << 36) - 64'd1;
         2:       return 64'd3;
         4:       return (64'd1 << 34) - 64'd1;
         default: return (64'd1 << 19) - 64'd1;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int B0 = g * 5;
      logic        aw_r, w_r, b_r, ar_r, r_r, aw_v, w_v, b_v, ar_v, r_v, bsy;
      logic [15:0] aw_a, ar_a;
      logic [2:0]  aw_p, ar_p;
      logic [31:0] w_d, r_d;
      logic [3:0]  w_s;
      logic [1:0]  b_rs, r_rs;

      axi_lite_multicut_cfg #(
         .ADDR_WIDTH(16), .DATA_WIDTH(32),
         .AW_CUTS(ncut(B0)), .W_CUTS(ncut(B0+1)), .B_CUTS(ncut(B0+2)),
         .AR_CUTS(ncut(B0+3)), .R_CUTS(ncut(B0+4)), .CUT_MODE(g)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .in_aw_addr_i(src_dat[B0][15:0]), .in_aw_prot_i(src_dat[B0][18:16]),
         .in_aw_valid_i(src_vld[B0]), .in_aw_ready_o(aw_r),
         .in_w_data_i(src_dat[B0+1][31:0]), .in_w_strb_i(src_dat[B0+1][35:32]),
         .in_w_valid_i(src_vld[B0+1]), .in_w_ready_o(w_r),
         .in_b_resp_o(b_rs), .in_b_valid_o(b_v), .in_b_ready_i(dst_rdy[B0+2]),
         .in_ar_addr_i(src_dat[B0+3][15:0]), .in_ar_prot_i(src_dat[B0+3][18:16]),
         .in_ar_valid_i(src_vld[B0+3]), .in_ar_ready_o(ar_r),
         .in_r_data_o(r_d), .in_r_resp_o(r_rs), .in_r_valid_o(r_v), .in_r_ready_i(dst_rdy[B0+4]),
         .out_aw_addr_o(aw_a), .out_aw_prot_o(aw_p), .out_aw_valid_o(aw_v), .out_aw_ready_i(dst_rdy[B0]),
         .out_w_data_o(w_d), .out_w_strb_o(w_s), .out_w_valid_o(w_v), .out_w_ready_i(dst_rdy[B0+1]),
         .out_b_resp_i(src_dat[B0+2][1:0]), .out_b_valid_i(src_vld[B0+2]), .out_b_ready_o(b_r),
         .out_ar_addr_o(ar_a), .out_ar_prot_o(ar_p), .out_ar_valid_o(ar_v), .out_ar_ready_i(dst_rdy[B0+3]),
         .out_r_data_i(src_dat[B0+4][31:0]), .out_r_resp_i(src_dat[B0+4][33:32]),
         .out_r_valid_i(src_vld[B0+4]), .out_r_ready_o(r_r),
         .busy_o(bsy)
      );

      assign src_rdy[B0]   = aw_r;
      assign src_rdy[B0+1] = w_r;
      assign src_rdy[B0+2] = b_r;
      assign src_rdy[B0+3] = ar_r;
      assign src_rdy[B0+4] = r_r;
      assign dst_vld[B0]   = aw_v;
      assign dst_vld[B0+1] = w_v;
      assign dst_vld[B0+2] = b_v;
      assign dst_vld[B0+3] = ar_v;
      assign dst_vld[B0+4] = r_v;
      assign dst_dat[B0]   = {45'd0, aw_p, aw_a};
      assign dst_dat[B0+1] = {28'd0, w_s, w_d};
      assign dst_dat[B0+2] = {62'd0, b_rs};
      assign dst_dat[B0+3] = {45'd0, ar_p, ar_a};
      assign dst_dat[B0+4] = {30'd0, r_rs, r_d};
      assign busy[g]       = bsy;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: beats in flight per channel; occupancy drives busy and ready rules.
   always @(negedge clk) begin
      int          n, occ, t;
      logic        any, pop;
      logic [63:0] e;
      if (rst_n) begin
         stamp++;
         for (int g = 0; g < 2; g++) begin
            any = 1'b0;
            for (int k = 0; k < 5; k++) if (sbq[g*5+k].size() != 0) any = 1'b1;
            chk($sformatf("busy inst%0d", g), 64'(busy[g]), 64'(any));
         end
         for (int ch = 0; ch < 10; ch++) begin
            n   = ncut(ch);
            occ = sbq[ch].size();
            pop = dst_vld[ch] && dst_rdy[ch];
            if (n == 0) begin
               chk($sformatf("pass_valid ch%0d", ch), 64'(dst_vld[ch]), 64'(src_vld[ch]));
               chk($sformatf("pass_data ch%0d", ch), dst_dat[ch], src_dat[ch]);
               chk($sformatf("pass_ready ch%0d", ch), 64'(src_rdy[ch]), 64'(dst_rdy[ch]));
            end else if (ch >= 5) begin
               chk($sformatf("fwd_ready ch%0d", ch), 64'(src_rdy[ch]),
                   64'(!(occ == n && !dst_rdy[ch])));
            end
            if (src_vld[ch] && src_rdy[ch]) begin
               if (n > 0)
                  chk($sformatf("capacity ch%0d", ch),
                      64'((occ - int'(pop)) < ((ch >= 5) ? n : 2 * n)), 64'd1);
               sbq[ch].push_back(src_dat[ch]);
               tsq[ch].push_back(stamp);
            end
            if (pop) begin
               if (sbq[ch].size() == 0) begin
                  n_chk++;
                  $display("FAIL sb_extra ch%0d: got beat %0h required none pending", ch, dst_dat[ch]);
               end else begin
                  e = sbq[ch].pop_front();
                  t = tsq[ch].pop_front();
                  chk($sformatf("sb_data ch%0d", ch), dst_dat[ch], e);
                  chk($sformatf("latency_min ch%0d", ch), 64'((stamp - t) >= n), 64'd1);
               end
            end
         end
      end
   end

   initial begin
      logic        ov [8];
      logic [63:0] od [8];
      logic [63:0] got [8];
      logic        hs [10];
      int          acc, rcv, sent, cnt;
      logic        tog;

      rst_n = 1'b0;
      for (int ch = 0; ch < 10; ch++) begin
         src_vld[ch] = 1'b0;
         src_dat[ch] = 64'd0;
         dst_rdy[ch] = 1'b0;
         hs[ch]      = 1'b0;
      end
      #2;
      // Reset state.
      for (int ch = 0; ch < 10; ch++) chk($sformatf("rst_valid ch%0d", ch), 64'(dst_vld[ch]), 64'd0);
      chk("rst_busy0", 64'(busy[0]), 64'd0);
      chk("rst_busy1", 64'(busy[1]), 64'd0);
      chk("rst_full_ready aw", 64'(src_rdy[0]), 64'd0);
      chk("rst_full_ready w", 64'(src_rdy[1]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("ready_after_rst", 64'(src_rdy[0]), 64'd1);

      // AW, 3 full stages, ready high: three addresses exit 3 cycles later, back-to-back.
      dst_rdy[0] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         src_vld[0] = (i < 3);
         src_dat[0] = 64'h100 + 64'(4 * i);
         @(negedge clk);
         ov[i] = dst_vld[0];
         od[i] = dst_dat[0];
         chk($sformatf("aw_in_ready c%0d", i), 64'(src_rdy[0]), 64'd1);
         step();
      end
      src_vld[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("aw_lat_valid c%0d", i), 64'(ov[i]), 64'(i >= 3 && i < 6));
         if (i >= 3 && i < 6) chk($sformatf("aw_lat_addr c%0d", i), od[i], 64'h100 + 64'(4 * (i - 3)));
      end

      // AR with no stages: same-cycle pass-through of valid, payload and ready.
      src_dat[3] = {45'd0, 3'd5, 16'hBEEF};
      src_vld[3] = 1'b1;
      dst_rdy[3] = 1'b0;
      #1;
      chk("ar_direct_valid", 64'(dst_vld[3]), 64'd1);
      chk("ar_direct_data", dst_dat[3], 64'h5BEEF);
      chk("ar_direct_ready_lo", 64'(src_rdy[3]), 64'd0);
      dst_rdy[3] = 1'b1;
      #1;
      chk("ar_direct_ready_hi", 64'(src_rdy[3]), 64'd1);
      @(negedge clk);
      step();
      src_vld[3] = 1'b0;

      // Forward-stage AW (1 stage): one beat per cycle with ready high, 1-cycle latency.
      dst_rdy[5] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         src_vld[5] = (i < 5);
         src_dat[5] = 64'h200 + 64'(i);
         @(negedge clk);
         if (i < 5) chk($sformatf("fwd_tput_ready c%0d", i), 64'(src_rdy[5]), 64'd1);
         ov[i] = dst_vld[5];
         step();
      end
      src_vld[5] = 1'b0;
      for (int i = 0; i < 7; i++) chk($sformatf("fwd_tput_valid c%0d", i), 64'(ov[i]), 64'(i >= 1 && i <= 5));

      // W, 2 full stages, stalled: exactly 4 beats absorbed, then drained in order.
      dst_rdy[1] = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         src_vld[1] = 1'b1;
         src_dat[1] = 64'hF000000D0 + 64'(acc);
         @(negedge clk);
         if (src_rdy[1]) acc++;
         step();
      end
      chk("w_absorbed", 64'(acc), 64'd4);
      chk("w_ready_low", 64'(src_rdy[1]), 64'd0);
      src_vld[1] = 1'b0;
      dst_rdy[1] = 1'b1;
      rcv = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (dst_vld[1] && rcv < 8) begin
            got[rcv] = dst_dat[1];
            rcv++;
         end
         step();
      end
      chk("w_drained", 64'(rcv), 64'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("w_order %0d", k), got[k], 64'hF000000D0 + 64'(k));

      // R, 2 forward stages, consumer ready toggling: A0..A3 arrive in order.
      sent = 0;
      rcv  = 0;
      tog  = 1'b1;
      for (int i = 0; i < 40 && rcv < 4; i++) begin
         src_vld[9] = (sent < 4);
         src_dat[9] = 64'h1000000A0 + 64'(sent);
         dst_rdy[9] = tog;
         tog        = ~tog;
         @(negedge clk);
         if (src_vld[9] && src_rdy[9]) sent++;
         if (dst_vld[9] && dst_rdy[9]) begin
            got[rcv] = dst_dat[9];
            rcv++;
         end
         step();
      end
      src_vld[9] = 1'b0;
      dst_rdy[9] = 1'b0;
      chk("r_received", 64'(rcv), 64'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("r_order %0d", k), got[k], 64'h1000000A0 + 64'(k));

      // B, 1 full stage: hold resp=2 with consumer stalled, then reset mid-transfer.
      src_dat[2] = 64'd2;
      src_vld[2] = 1'b1;
      dst_rdy[2] = 1'b0;
      @(negedge clk);
      step();
      src_vld[2] = 1'b0;
      #1;
      chk("b_held_valid", 64'(dst_vld[2]), 64'd1);
      chk("b_held_resp", dst_dat[2], 64'd2);
      chk("b_held_busy", 64'(busy[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("b_rst_valid", 64'(dst_vld[2]), 64'd0);
      chk("b_rst_busy", 64'(busy[0]), 64'd0);
      chk("b_rst_full_ready", 64'(src_rdy[0]), 64'd0);
      for (int ch = 0; ch < 10; ch++) begin
         sbq[ch].delete();
         tsq[ch].delete();
      end
      @(negedge clk);
      rst_n = 1'b1;
      dst_rdy[2] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (dst_vld[2]) cnt++;
         step();
      end
      chk("b_after_rst_beats", 64'(cnt), 64'd0);

      // Random valid/ready on every channel; the scoreboard checks each beat.
      for (int c = 0; c < 3000; c++) begin
         for (int ch = 0; ch < 10; ch++) begin
            if (!src_vld[ch] || hs[ch]) begin
               src_vld[ch] = ($urandom_range(0, 3) != 0);
               src_dat[ch] = {$urandom, $urandom} & cmask(ch);
            end
            dst_rdy[ch] = ($urandom_range(0, 3) != 0);
         end
         @(negedge clk);
         for (int ch = 0; ch < 10; ch++) hs[ch] = src_vld[ch] && src_rdy[ch];
         step();
      end
      for (int ch = 0; ch < 10; ch++) begin
         if (hs[ch]) src_vld[ch] = 1'b0;
         dst_rdy[ch] = 1'b1;
      end
      // Let any still-pending beats be accepted, then drain.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         for (int ch = 0; ch < 10; ch++) hs[ch] = src_vld[ch] && src_rdy[ch];
         step();
         for (int ch = 0; ch < 10; ch++) if (hs[ch]) src_vld[ch] = 1'b0;
      end
      for (int ch = 0; ch < 10; ch++) chk($sformatf("drain_empty ch%0d", ch), 64'(sbq[ch].size()), 64'd0);
      chk("drain_busy0", 64'(busy[0]), 64'd0);
      chk("drain_busy1", 64'(busy[1]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/axi_lite_multicut_cfg.md
AXI_LITE_MULTICUT_CFG -- requirements
Module: axi_lite_multicut_cfg

Interface
REQ-001 Parameter ADDR_WIDTH, default -1, SHALL set the AXI-Lite address width; values < 1 are illegal.
REQ-002 Parameter DATA_WIDTH, default -1, SHALL set the AXI-Lite data width; SHALL be a multiple of 8 and >= 8.
REQ-003 Parameters AW_CUTS, W_CUTS, B_CUTS, AR_CUTS, R_CUTS, default 1 each, SHALL set the number of register stages on that channel; each SHALL be >= 0.
REQ-004 Parameter CUT_MODE, default 0, SHALL select the stage type for all stages: 0 = full spill stage (valid/data and ready both registered), 1 = forward stage (valid/data registered, ready combinational).
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 in  AXI_LITE.in  ADDR_WIDTH/DATA_WIDTH  upstream (master-facing) AXI-Lite port.
REQ-008 out  AXI_LITE.out  ADDR_WIDTH/DATA_WIDTH  downstream (slave-facing) AXI-Lite port.
REQ-009 busy_o  output  1  high while any stage on any channel holds a valid beat.

Function
REQ-010 Each channel SHALL be an independent chain of its configured stage count; AW, W, AR carry in->out, B, R carry out->in.
REQ-011 Payload per beat SHALL be: AW/AR = addr+prot, W = data+strb, B = resp, R = data+resp; all fields SHALL pass bit-exact.
REQ-012 A channel with 0 stages SHALL be a direct combinational connection, including valid and ready.
REQ-013 A beat SHALL transfer between stages only when valid && ready are both high in the same cycle; payload SHALL not change while a stage holds it.
REQ-014 Latency through N stages SHALL be exactly N cycles when downstream ready is held high.
REQ-015 Sustained throughput SHALL be one beat per cycle per channel in both modes when downstream ready is held high.
REQ-016 Full stage: 2 entries (main + spill); upstream ready SHALL be registered, high iff spill entry empty; output SHALL come from main entry.
REQ-017 Full stage states: EMPTY -> ONE on push; ONE -> EMPTY on pop without push; ONE -> TWO on push without pop; ONE stays ONE on simultaneous push+pop; TWO -> ONE on pop; no push accepted in TWO.
REQ-018 Forward stage: 1 entry; upstream ready SHALL equal (!valid_q || downstream ready); simultaneous pop and push SHALL replace the entry in one cycle.
REQ-019 With downstream ready low, a chain SHALL absorb exactly 2*N (mode 0) or N (mode 1) beats before upstream ready deasserts.
REQ-020 Beat order per channel SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-021 No combinational path SHALL exist from any out ready to any in ready, or in valid to out valid, on channels with >= 1 stage in mode 0.
REQ-022 busy_o SHALL be the OR of all stage valid flags, registered-state only (no combinational input dependency).
REQ-023 Elaboration SHALL fail (simulation assertion) on any negative cut count or CUT_MODE outside {0,1}.

Reset
REQ-024 On rst_ni low, all stage valid flags SHALL clear asynchronously; all out valids and in B/R valids of staged channels SHALL be 0; busy_o SHALL be 0.
REQ-025 During reset, full-stage upstream ready SHALL be 0; after release, it SHALL be 1 from the first rising edge onward.
REQ-026 Reset mid-transfer SHALL discard all held beats; payload registers need not be reset.

Verification
REQ-027 AW_CUTS=3, mode 0, out.aw_ready=1; push addr 0x100,0x104,0x108 back-to-back -> out.aw_valid from cycle 3, same order, one per cycle.
REQ-028 W_CUTS=2, mode 0, out.w_ready=0; drive continuous W beats -> in.w_ready deasserts after exactly 4 accepted; release ready -> 4 beats exit in order, no loss.
REQ-029 R_CUTS=2, mode 1, out.r_valid continuous, in.r_ready toggling 1,0,1,0 -> beats data 0xA0..0xA3 arrive in order, out.r_ready low whenever both stages full and in.r_ready low.
REQ-030 All cuts 0 -> every output equals its input in the same cycle; busy_o constantly 0.
REQ-031 B_CUTS=1, mode 0, one beat resp=2'b10 held with in.b_ready=0, assert rst_ni=0 -> in.b_valid and busy_o fall immediately; after release no B beat emerges.
REQ-032 Random valid/ready on all five channels, mixed cut counts, 10k beats -> scoreboard shows order and payload match, one beat per cycle peak throughput.
